mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU control FSM's memory requests (fetch, LR, SR).
//  Accepts one read or write request, inserts a programmable number of wait states,
//  performs the access on an internal word array, then signals completion.
//  Sits between the datapath address/data muxes and the storage array.
// PARAMETERS
//  ADDR_WIDTH   8    word-address width
//  DATA_WIDTH   16   word width
//  DEPTH        256  implemented words; valid addresses 0..DEPTH-1, DEPTH <= 2**ADDR_WIDTH
//  WAIT_CYCLES  2    extra ACCESS cycles before the access commits; 0 is legal
// PORTS
//  clk      in   1           clock, rising edge
//  reset    in   1           asynchronous, active-low reset
//  req      in   1           request strobe, sampled only in IDLE
//  rnw      in   1           1 = read, 0 = write; captured with req
//  addr     in   ADDR_WIDTH  word address; captured with req
//  wdata    in   DATA_WIDTH  write data; captured with req
//  busy     out  1           high from the cycle after acceptance through DONE
//  ready    out  1           one-cycle completion pulse
//  rdata    out  DATA_WIDTH  last read word; valid while ready=1 for reads, then held
//  err      out  1           range-error flag; exists only with MEM_RANGE_CHECK_EN
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE, busy=0, ready=0, rdata=0, err=0, counter=0.
//   Array contents are not cleared.
//  FSM states and transitions:
//   IDLE  : req=1 -> latch rnw/addr/wdata, load cnt=WAIT_CYCLES, go to ACCESS. req=0 -> stay.
//   ACCESS: cnt!=0 -> cnt-1, stay. cnt==0 -> commit and go to DONE.
//     Commit for a write: mem[addr] <= wdata. Commit for a read: rdata <= mem[addr].
//   DONE  : ready=1 for exactly one cycle, then IDLE unconditionally.
//  busy = (state != IDLE); ready = (state == DONE); both are registered-state decodes.
//  Latency: req high in IDLE cycle N -> ready high in cycle N+WAIT_CYCLES+2.
//  Throughput: the next request is accepted at the earliest in cycle N+WAIT_CYCLES+3.
//  req in ACCESS or DONE is ignored and not queued; the requester re-asserts after ready.
//  Changes to rnw/addr/wdata after acceptance have no effect; the latched copies are used.
//  rdata holds its value across writes and idle cycles and changes only on a read commit.
//  Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
//   WAIT_CYCLES=0 gives exactly one ACCESS cycle.
//  Reset asserted in ACCESS before the commit edge: the access is dropped and memory is unchanged.
//   After release the FSM resumes in IDLE.
//  Address >= DEPTH without the macro: the address wraps modulo DEPTH (low bits index the array).
// CONFIGURATION
//  MEM_RANGE_CHECK_EN defined:
//   A latched addr >= DEPTH suppresses the write, and a read returns rdata=0.
//   err=1 in the DONE cycle only; timing is otherwise unchanged.
//  MEM_RANGE_CHECK_EN undefined:
//   No err port and no check logic; out-of-range addresses wrap as described above.
// TESTING
//  1. WAIT_CYCLES=2, write 0x1234 to addr 5 at cycle 10 -> busy 11..14, ready only in cycle 14.
//     Read of addr 5 then -> rdata=0x1234 with ready.
//  2. WAIT_CYCLES=0, read at cycle N -> ready in cycle N+2.
//     Back-to-back reads of addr 3 and addr 4 (0xAAAA, 0x5555) -> both values returned in order.
//  3. Second req pulses during ACCESS and during DONE -> ignored.
//     Exactly one ready; memory touched only by the first request.
//  4. Write 0xBEEF to addr 7 after a prior 0x0001 at addr 7.
//     Pull reset low in the first ACCESS cycle -> busy/ready drop immediately; later read of addr 7 = 0x0001.
//  5. Change addr/wdata on the cycle after acceptance -> the originally latched address and data are used.
//  6. MEM_RANGE_CHECK_EN, DEPTH=200, write 0x7777 to addr 210 -> err=1 with ready, no array change.
//     Read of addr 210 -> rdata=0, err=1. Without the macro, addr 210 aliases addr 10.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester and mem_responder.
// The err signal exists only when MEM_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
`ifdef MEM_RANGE_CHECK_EN
  logic                  err;
`endif

  // Handshake: a request is accepted on a rising edge where the responder
  // is idle (busy=0) and req=1; rnw/addr/wdata are captured on that edge.
  // req while busy is dropped, not queued. ready pulses for one cycle when
  // the access has completed; rdata is valid with ready on reads.
  modport master (
    output req, rnw, addr, wdata,
`ifdef MEM_RANGE_CHECK_EN
    input  err,
`endif
    input  busy, ready, rdata
  );

  modport slave (
    input  req, rnw, addr, wdata,
`ifdef MEM_RANGE_CHECK_EN
    output err,
`endif
    output busy, ready, rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, WAIT_CYCLES extra cycles, then a ready pulse.
// Optional MEM_RANGE_CHECK_EN: out-of-range addresses are flagged on err instead of wrapping.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  output logic [1:0]           dbg_state_o
);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  commit;
  logic                  range_ok;
  logic                  mem_we;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Addresses past DEPTH wrap modulo DEPTH, which also keeps the index legal
  // when the range check is enabled.
  assign idx = IDX_W'(32'(addr_q) % 32'(DEPTH));

`ifdef MEM_RANGE_CHECK_EN
  logic err_q, err_d;
  assign range_ok = (32'(addr_q) < 32'(DEPTH));
`else
  assign range_ok = 1'b1;
`endif

  assign mem_we = commit && !rnw_q && range_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          rnw_d   = bus.rnw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit && rnw_q) rdata_d = range_ok ? mem_q[idx] : '0;
  end

`ifdef MEM_RANGE_CHECK_EN
  assign err_d = commit && !range_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage is never cleared; a reset during ACCESS forces IDLE so the write is dropped.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wdata_q;
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.ready   = (state_q == S_DONE);
  assign bus.rdata   = rdata_q;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.err     = err_q;
`endif
  assign dbg_state_o = state_q;
endmodule
